// File: rtl/conf_int_mul_pkg.sv
// ============================================================================
// Module   : conf_int_mul_pkg
// Brief    : Mode codes and FSM state encoding shared by the multiplier
//            mode controller and its helpers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package conf_int_mul_pkg;

  typedef logic [1:0] mode_code_t;
  typedef logic [2:0] state_t;

  // {racc,rapx}: a path is released when its reset bit is low
  localparam mode_code_t MODE_OFF = 2'b11;
  localparam mode_code_t MODE_ACC = 2'b01;
  localparam mode_code_t MODE_APX = 2'b10;

  localparam state_t S_OFF    = 3'd0;
  localparam state_t S_SETTLE = 3'd1;
  localparam state_t S_IDLE   = 3'd2;
  localparam state_t S_EXEC   = 3'd3;
  localparam state_t S_RESP   = 3'd4;

  function automatic mode_code_t mode_code(input logic apx);
    return apx ? MODE_APX : MODE_ACC;
  endfunction

endpackage

`default_nettype wire

// File: rtl/conf_int_mul_settle_cnt.sv
// ============================================================================
// Module   : conf_int_mul_settle_cnt
// Brief    : Loadable down-counter with zero flag; saturates at zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module conf_int_mul_settle_cnt #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - WIDTH'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/conf_int_mul_mode_ctrl.sv
// ============================================================================
// Module   : conf_int_mul_mode_ctrl
// Brief    : Sequences accurate/approximate multiplier path resets and
//            handshakes operands/results around an external multiplier.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module conf_int_mul_mode_ctrl
  import conf_int_mul_pkg::*;
#(
  parameter int OP_BITWIDTH        = 28,
  parameter int DATA_PATH_BITWIDTH = 32,
  parameter int SETTLE_CYCLES      = 2,
  parameter int IDLE_TIMEOUT       = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_apx,
  input  logic [DATA_PATH_BITWIDTH-1:0] in_a,
  input  logic [DATA_PATH_BITWIDTH-1:0] in_b,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_PATH_BITWIDTH-1:0] out_d,
  output logic                          out_apx,
  output logic                          racc,
  output logic                          rapx,
  output logic [DATA_PATH_BITWIDTH-1:0] mul_a,
  output logic [DATA_PATH_BITWIDTH-1:0] mul_b,
  input  logic [DATA_PATH_BITWIDTH-1:0] mul_d
);

  if (OP_BITWIDTH > DATA_PATH_BITWIDTH || SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15 ||
      IDLE_TIMEOUT < 1 || IDLE_TIMEOUT > 255) begin : g_param_check
    $error("conf_int_mul_mode_ctrl: parameter out of range");
  end

  localparam logic [3:0] c_settle_load = 4'(SETTLE_CYCLES - 1);
  localparam logic [7:0] c_idle_load   = 8'(IDLE_TIMEOUT - 1);

  state_t     r_state;
  mode_code_t r_mode;
  logic       r_exec_apx;

  logic       w_match;
  logic       w_settle_load;
  logic       w_settle_dec;
  logic       w_settle_zero;
  logic       w_idle_load;
  logic       w_idle_dec;
  logic       w_idle_zero;

  assign w_match  = (in_apx == (r_mode == MODE_APX));
  assign in_ready = (r_state == S_IDLE) && in_valid && w_match;
  assign {racc, rapx} = r_mode;

  assign w_settle_load = in_valid && ((r_state == S_OFF) || ((r_state == S_IDLE) && !w_match));
  assign w_settle_dec  = (r_state == S_SETTLE);
  // Idle counter restarts on any request and whenever we are not idling.
  assign w_idle_load   = (r_state != S_IDLE) || in_valid;
  assign w_idle_dec    = (r_state == S_IDLE) && !in_valid;

  conf_int_mul_settle_cnt #(.WIDTH(4)) u_settle_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_settle_load),
    .i_load_val (c_settle_load),
    .i_dec      (w_settle_dec),
    .o_zero     (w_settle_zero)
  );

  conf_int_mul_settle_cnt #(.WIDTH(8)) u_idle_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_idle_load),
    .i_load_val (c_idle_load),
    .i_dec      (w_idle_dec),
    .o_zero     (w_idle_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_OFF;
      r_mode     <= MODE_OFF;
      r_exec_apx <= 1'b0;
      out_valid  <= 1'b0;
      out_d      <= '0;
      out_apx    <= 1'b0;
      mul_a      <= '0;
      mul_b      <= '0;
    end else begin
      case (r_state)
        S_OFF: begin
          if (in_valid) begin
            r_mode  <= mode_code(in_apx);
            r_state <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (w_settle_zero) begin
            r_state <= S_IDLE;
          end
        end
        S_IDLE: begin
          if (in_valid) begin
            if (w_match) begin
              mul_a      <= in_a;
              mul_b      <= in_b;
              r_exec_apx <= in_apx;
              r_state    <= S_EXEC;
            end else begin
              // Switch paths directly; never pass through both-held or both-released.
              r_mode  <= mode_code(in_apx);
              r_state <= S_SETTLE;
            end
          end else if (w_idle_zero) begin
            r_mode  <= MODE_OFF;
            r_state <= S_OFF;
          end
        end
        S_EXEC: begin
          out_d     <= mul_d;
          out_apx   <= r_exec_apx;
          out_valid <= 1'b1;
          r_state   <= S_RESP;
        end
        S_RESP: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          r_mode  <= MODE_OFF;
          r_state <= S_OFF;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_conf_int_mul_mode_ctrl.sv
// ============================================================================
// Module   : tb_conf_int_mul_mode_ctrl
// Brief    : Directed and randomised self-checking bench for the mode controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_conf_int_mul_mode_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_apx = 1'b0;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_d;
  logic        out_apx;
  logic        racc;
  logic        rapx;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [31:0] mul_d;

  int n_checks = 0;
  int n_fail   = 0;
  logic cur_apx = 1'b0;
  logic is_off  = 1'b1;

  always #5 clk = ~clk;

  // Approximate path only sees the low 28 operand bits (sign-extended).
  function automatic logic [31:0] ref_mul(input logic apx, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] sa;
    logic [31:0] sb;
    sa = apx ? {{4{a[27]}}, a[27:0]} : a;
    sb = apx ? {{4{b[27]}}, b[27:0]} : b;
    return sa * sb;
  endfunction

  assign mul_d = ref_mul(!rapx, mul_a, mul_b);

  conf_int_mul_mode_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_apx    (in_apx),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_d     (out_d),
    .out_apx   (out_apx),
    .racc      (racc),
    .rapx      (rapx),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_d     (mul_d)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic apx, input logic [31:0] a, input logic [31:0] b,
                        input int exp_wait, input int rdy_delay);
    int          w;
    logic [31:0] exp_d;
    exp_d    = ref_mul(apx, a, b);
    in_valid = 1'b1;
    in_apx   = apx;
    in_a     = a;
    in_b     = b;
    #1;
    w = 0;
    while (!in_ready && w < 40) begin
      if (w > 0) check_eq("mode_during_settle", {racc, rapx}, apx ? 2'b10 : 2'b01);
      cyc();
      w++;
    end
    check_eq("accept_wait", w, exp_wait);
    cyc();
    in_valid = 1'b0;
    in_a     = $urandom;
    in_b     = $urandom;
    check_eq("exec_no_valid", out_valid, 1'b0);
    check_eq("mul_a", mul_a, a);
    check_eq("mul_b", mul_b, b);
    cyc();
    check_eq("resp_valid", out_valid, 1'b1);
    check_eq("resp_d", out_d, exp_d);
    check_eq("resp_apx", out_apx, apx);
    for (int k = 0; k < rdy_delay; k++) begin
      in_valid = 1'b1;
      in_apx   = apx;
      in_a     = ~a;
      #1;
      check_eq("resp_in_ready", in_ready, 1'b0);
      cyc();
      check_eq("hold_valid", out_valid, 1'b1);
      check_eq("hold_d", out_d, exp_d);
      check_eq("hold_mul_a", mul_a, a);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    check_eq("resp_done", out_valid, 1'b0);
    cur_apx = apx;
    is_off  = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        r_apx;
    logic [31:0] ra;
    logic [31:0] rb;

    // Reset state
    #12;
    check_eq("rst_mode", {racc, rapx}, 2'b11);
    check_eq("rst_in_ready", in_ready, 1'b0);
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_out_d", out_d, 32'd0);
    check_eq("rst_out_apx", out_apx, 1'b0);
    check_eq("rst_mul_a", mul_a, 32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();

    run_op(1'b1, 32'd7, 32'd6, 3, 0);
    run_op(1'b0, 32'hFFFF_FFFD, 32'd5, 3, 0);
    run_op(1'b1, 32'd3, 32'd4, 3, 0);
    run_op(1'b1, 32'd100, 32'hFFFF_FFFE, 0, 5);

    // Idle timeout: 16 idle cycles with no request returns both paths to reset
    for (int i = 1; i <= 16; i++) begin
      if (i == 16) check_eq("idle16_mode", {racc, rapx}, 2'b10);
      cyc();
    end
    check_eq("timeout_mode", {racc, rapx}, 2'b11);
    check_eq("timeout_in_ready", in_ready, 1'b0);
    is_off = 1'b1;
    run_op(1'b0, 32'd9, 32'd9, 3, 0);

    // Request on the 16th idle cycle is accepted without going OFF
    repeat (15) cyc();
    run_op(1'b0, 32'h7FFF_FFFF, 32'd3, 0, 1);

    // Reset asserted during EXEC
    in_valid = 1'b1;
    in_apx   = 1'b0;
    in_a     = 32'd11;
    in_b     = 32'd13;
    #1;
    check_eq("pre_rst_ready", in_ready, 1'b1);
    cyc();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check_eq("exec_rst_mode", {racc, rapx}, 2'b11);
    check_eq("exec_rst_valid", out_valid, 1'b0);
    check_eq("exec_rst_mul_a", mul_a, 32'd0);
    check_eq("exec_rst_out_d", out_d, 32'd0);
    cyc();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check_eq("post_rst_valid", out_valid, 1'b0);
    end
    out_ready = 1'b0;
    is_off    = 1'b1;
    run_op(1'b1, 32'h0FFF_FFFF, 32'h1234_5678, 3, 0);

    // Random operands, modes and backpressure
    for (int n = 0; n < 500; n++) begin
      r_apx = 1'($urandom_range(0, 1));
      ra    = $urandom;
      rb    = $urandom;
      run_op(r_apx, ra, rb, (is_off || (r_apx != cur_apx)) ? 3 : 0, $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/conf_int_mul_mode_ctrl.md
CONF_INT_MUL_MODE_CTRL -- requirements
Module: conf_int_mul_mode_ctrl

Interface
REQ-001 Parameter OP_BITWIDTH, default 28, multiplier operand width handled by the wrapped datapath.
REQ-002 Parameter DATA_PATH_BITWIDTH, default 32, width of operand/result buses.
REQ-003 Parameter SETTLE_CYCLES, default 2, cycles a newly released mode path is held before use (range 1..15).
REQ-004 Parameter IDLE_TIMEOUT, default 16, idle cycles before both paths are put back in reset (range 1..255).
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 in_valid  input  1  operation request.
REQ-008 in_ready  output  1  request accepted when in_valid&in_ready at clock edge.
REQ-009 in_apx  input  1  requested mode: 1 approximate, 0 accurate.
REQ-010 in_a, in_b  input  DATA_PATH_BITWIDTH  operands.
REQ-011 out_valid  output  1  result available.
REQ-012 out_ready  input  1  consumer accepts result when out_valid&out_ready.
REQ-013 out_d  output  DATA_PATH_BITWIDTH  product captured from multiplier.
REQ-014 out_apx  output  1  mode in which out_d was computed.
REQ-015 racc, rapx  output  1 each  active-high path resets to the multiplier wrapper.
REQ-016 mul_a, mul_b  output  DATA_PATH_BITWIDTH  registered operands to multiplier; mul_d  input  DATA_PATH_BITWIDTH  combinational product.

Function
REQ-017 Mode encoding on {racc,rapx}: OFF = 11, ACC = 01, APX = 10; 00 SHALL never be driven.
REQ-018 FSM states OFF, SETTLE, IDLE, EXEC, RESP; exactly one active.
REQ-019 OFF: {racc,rapx}=11, in_ready=0; on in_valid load target mode from in_apx, drive its code next cycle, go SETTLE.
REQ-020 SETTLE: counter loads SETTLE_CYCLES-1, decrements each cycle; at zero go IDLE; in_ready=0.
REQ-021 IDLE: in_ready=1 only if in_valid and in_apx equals current mode; on handshake register in_a/in_b onto mul_a/mul_b, latch in_apx, go EXEC.
REQ-022 IDLE with in_valid and mismatched in_apx: in_ready=0, drive new mode code directly (no 11 or 00 intermediate), go SETTLE.
REQ-023 EXEC lasts exactly one cycle; at its end capture mul_d into out_d, set out_valid, go RESP.
REQ-024 RESP: hold out_valid, out_d, out_apx stable until out_ready; on handshake clear out_valid, go IDLE; in_ready=0 throughout.
REQ-025 Latency: accepted request to out_valid = 2 cycles when mode already active.
REQ-026 Idle counter counts consecutive IDLE cycles without in_valid; reaching IDLE_TIMEOUT goes OFF (drive 11); any in_valid clears it; in_valid in the same cycle as expiry wins (no OFF transition).
REQ-027 mul_a/mul_b hold last accepted operands outside EXEC; no operand changes while EXEC or RESP.
REQ-028 Requester SHALL see in_ready deasserted during any mode change; a held request is accepted in the first IDLE cycle after SETTLE.

Reset
REQ-029 rst_n low asynchronously forces: state OFF, {racc,rapx}=11, in_ready=0, out_valid=0, out_d=0, out_apx=0, mul_a=mul_b=0, all counters 0.
REQ-030 Reset mid-EXEC or mid-RESP discards the operation; no out_valid after rst_n rises until a new request completes.
REQ-031 First request after reset always passes through SETTLE.

Structure
REQ-032 Shared package conf_int_mul_pkg holds mode-code constants (OFF/ACC/APX) and FSM state encoding.
REQ-033 One sub-module, conf_int_mul_settle_cnt (loadable down-counter with zero flag), reused for settle and idle counting.
REQ-034 Multiplier wrapper instantiated outside this block; controller contains no arithmetic.

Verification
REQ-035 Reset then in_valid=1,in_apx=1,a=7,b=6 held -> {racc,rapx} 11->10, 2 SETTLE cycles, accept, out_d=42 (reference model), out_apx=1, 2 cycles after accept.
REQ-036 ACC op a=-3,b=5 completes, then APX request -> in_ready low, {racc,rapx} 01->10 with no 00/11 cycle, accept after SETTLE.
REQ-037 out_ready low 5 cycles in RESP -> out_d/out_valid stable, in_ready=0, no second accept.
REQ-038 No requests for 16 IDLE cycles -> OFF (11); request on 16th cycle -> no OFF transition.
REQ-039 rst_n pulsed low during EXEC -> outputs at reset values immediately, no spurious out_valid afterward.
REQ-040 500 random operand pairs, random mode and backpressure -> every result matches software model for its mode, in order, none dropped or duplicated.
